// File: rtl/exec_pkg.sv
// Shared types and op-code constants for the execute stage and its iterative multiplier.
package exec_pkg;

   localparam int ALU_CTRL_W = 4;
   localparam int BR_KIND_W  = 2;
   localparam int BR_COND_W  = 3;

   typedef enum logic [ALU_CTRL_W-1:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLL   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_SLT   = 4'd8,
      ALU_PASSB = 4'd9,
      ALU_MUL   = 4'd10
   } alu_op_e;

   typedef enum logic [BR_COND_W-1:0] {
      BR_EQ = 3'd0,
      BR_NE = 3'd1,
      BR_LT = 3'd2,
      BR_GE = 3'd3,
      BR_LE = 3'd4,
      BR_GT = 3'd5
   } br_cond_e;

   typedef enum logic [BR_KIND_W-1:0] {
      BR_NONE = 2'b00,
      BR_COND = 2'b01,
      BR_JUMP = 2'b10
   } br_kind_e;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_e;

   // Signed condition evaluation from precomputed less-than and equal flags.
   function automatic logic cond_true(input logic [BR_COND_W-1:0] cond,
                                      input logic lt, input logic eq);
      logic res;
      res = 1'b0;
      case (br_cond_e'(cond))
         BR_EQ:   res = eq;
         BR_NE:   res = !eq;
         BR_LT:   res = lt;
         BR_GE:   res = !lt;
         BR_LE:   res = lt | eq;
         BR_GT:   res = !(lt | eq);
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles per operation.
module exec_mul_iter
   import exec_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int CNT_W = $clog2(DATA_W);

   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] step_acc;
   logic              last;

   assign step_acc = mplier[0] ? (acc + mcand) : acc;
   assign last     = (count == CNT_W'(DATA_W - 1));

   // done and product reflect the final step combinationally so the caller can
   // capture the result on the same edge that retires the last step.
   assign done    = busy & last;
   assign product = step_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
         busy   <= 1'b0;
      end else if (start) begin
         acc    <= '0;
         mcand  <= a;
         mplier <= b;
         count  <= '0;
         busy   <= 1'b1;
      end else if (busy) begin
         acc    <= step_acc;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + CNT_W'(1);
         if (last) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/execute_stage.sv
// Registered execute stage: operand muxing, ALU, branch resolution, next-PC and flush,
// with an iterative multiplier behind a valid/ready handshake.
module execute_stage
   import exec_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int PC_W    = 13,
   parameter int INSTR_W = 16,
   parameter int IMMA_W  = 6,
   parameter int IMMB_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [PC_W-1:0]       pc_in,
   input  logic [DATA_W-1:0]     rqrd,
   input  logic [DATA_W-1:0]     rs,
   input  logic [INSTR_W-1:0]    instr,
   input  logic                  rqrd_or_imm,
   input  logic                  rs_or_imm,
   input  logic                  fwd_a,
   input  logic                  fwd_b,
   input  logic [ALU_CTRL_W-1:0] alu_ctrl,
   input  logic [BR_KIND_W-1:0]  br_kind,
   input  logic [BR_COND_W-1:0]  br_cond,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     alu_out,
   output logic [PC_W-1:0]       pc_out,
   output logic                  flush
);

   localparam int SHAMT_W = $clog2(DATA_W);

   state_e            state;
   state_e            state_next;
   alu_op_e           alu_op;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] alu_res;
   logic [SHAMT_W-1:0] shamt;
   logic              lt;
   logic              eq;
   logic              taken;
   logic [PC_W-1:0]   pc_seq;
   logic [PC_W-1:0]   br_off;
   logic [PC_W-1:0]   pc_next;
   logic              accept;
   logic              is_mul;
   logic              mul_start;
   logic              mul_busy;
   logic              mul_done;
   logic [DATA_W-1:0] mul_product;
   logic              unused_instr;

   assign unused_instr = ^instr[INSTR_W-1:IMMB_W];

   // Immediate select takes priority over forwarding; forwarding reuses the registered result.
   assign op_a = rqrd_or_imm ? DATA_W'(instr[IMMA_W-1:0]) : (fwd_a ? alu_out : rqrd);
   assign op_b = rs_or_imm   ? DATA_W'(instr[IMMB_W-1:0]) : (fwd_b ? alu_out : rs);

   assign alu_op = alu_op_e'(alu_ctrl);
   assign is_mul = (alu_op == ALU_MUL);
   assign shamt  = op_b[SHAMT_W-1:0];
   assign lt     = $signed(op_a) < $signed(op_b);
   assign eq     = (op_a == op_b);

   always_comb begin
      alu_res = op_b;
      case (alu_op)
         ALU_ADD:   alu_res = op_a + op_b;
         ALU_SUB:   alu_res = op_a - op_b;
         ALU_AND:   alu_res = op_a & op_b;
         ALU_OR:    alu_res = op_a | op_b;
         ALU_XOR:   alu_res = op_a ^ op_b;
         ALU_SLL:   alu_res = op_a << shamt;
         ALU_SRL:   alu_res = op_a >> shamt;
         ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
         ALU_SLT:   alu_res = {{(DATA_W-1){1'b0}}, lt};
         default:   alu_res = op_b;
      endcase
   end

   assign pc_seq = pc_in + PC_W'(1);
   assign br_off = PC_W'($signed(instr[IMMB_W-1:0]));

   always_comb begin
      taken   = 1'b0;
      pc_next = pc_seq;
      if (br_kind == BR_JUMP) begin
         taken   = 1'b1;
         pc_next = op_a[PC_W-1:0];
      end else if (br_kind == BR_COND && cond_true(br_cond, lt, eq)) begin
         taken   = 1'b1;
         pc_next = pc_in + br_off;
      end
   end

   assign in_ready = (state == IDLE) & !mul_busy & (!out_valid | out_ready);
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      mul_start  = 1'b0;
      case (state)
         IDLE: begin
            if (accept && is_mul) begin
               state_next = MUL;
               mul_start  = 1'b1;
            end
         end
         MUL: begin
            if (mul_done) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   exec_mul_iter #(
      .DATA_W (DATA_W)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (op_a),
      .b       (op_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // A MUL never branches, so its PC is captured as pc_in+1 at accept and flush stays low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         alu_out   <= '0;
         pc_out    <= '0;
         flush     <= 1'b0;
      end else if (mul_done) begin
         out_valid <= 1'b1;
         alu_out   <= mul_product;
         flush     <= 1'b0;
      end else if (accept) begin
         if (is_mul) begin
            out_valid <= 1'b0;
            pc_out    <= pc_seq;
            flush     <= 1'b0;
         end else begin
            out_valid <= 1'b1;
            alu_out   <= alu_res;
            pc_out    <= pc_next;
            flush     <= taken;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
         flush     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Directed, table-driven bench for execute_stage plus hand sequences for MUL, hold and reset.
module tb_execute_stage;
   import exec_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [12:0] pc_in;
   logic [31:0] rqrd;
   logic [31:0] rs;
   logic [15:0] instr;
   logic        rqrd_or_imm;
   logic        rs_or_imm;
   logic        fwd_a;
   logic        fwd_b;
   logic [3:0]  alu_ctrl;
   logic [1:0]  br_kind;
   logic [2:0]  br_cond;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_out;
   logic [12:0] pc_out;
   logic        flush;

   int pass_count;
   int check_count;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [15:0] ins;
      logic        a_imm;
      logic        b_imm;
      logic        fa;
      logic        fb;
      logic [1:0]  kind;
      logic [2:0]  cond;
      logic [12:0] pc;
      logic [31:0] e_alu;
      logic [12:0] e_pc;
      logic        e_flush;
   } vec_t;

   vec_t vq[$];

   execute_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .pc_in       (pc_in),
      .rqrd        (rqrd),
      .rs          (rs),
      .instr       (instr),
      .rqrd_or_imm (rqrd_or_imm),
      .rs_or_imm   (rs_or_imm),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b),
      .alu_ctrl    (alu_ctrl),
      .br_kind     (br_kind),
      .br_cond     (br_cond),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .alu_out     (alu_out),
      .pc_out      (pc_out),
      .flush       (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end else begin
         pass_count++;
      end
   endtask

   task automatic driveOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [15:0] ins, input logic a_imm, input logic b_imm,
                          input logic fa, input logic fb, input logic [1:0] kind,
                          input logic [2:0] cond, input logic [12:0] pc);
      in_valid    = 1'b1;
      alu_ctrl    = op;
      rqrd        = a;
      rs          = b;
      instr       = ins;
      rqrd_or_imm = a_imm;
      rs_or_imm   = b_imm;
      fwd_a       = fa;
      fwd_b       = fb;
      br_kind     = kind;
      br_cond     = cond;
      pc_in       = pc;
   endtask

   // Drive one vector for a single edge, then check the registered outputs 1 ns later.
   task automatic applyStimulus(input vec_t v);
      driveOp(v.op, v.a, v.b, v.ins, v.a_imm, v.b_imm, v.fa, v.fb, v.kind, v.cond, v.pc);
      checkOutput({v.name, ".in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      checkOutput({v.name, ".out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({v.name, ".alu_out"}, alu_out, v.e_alu);
      checkOutput({v.name, ".pc_out"}, 32'(pc_out), 32'(v.e_pc));
      checkOutput({v.name, ".flush"}, 32'(flush), 32'(v.e_flush));
   endtask

   initial begin
      int bad;
      pass_count = 0;
      check_count = 0;
      rst_n = 1'b0;
      out_ready = 1'b1;
      driveOp(4'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 13'd0);
      in_valid = 1'b0;

      // name, op, a, b, instr, a_imm, b_imm, fa, fb, kind, cond, pc, exp alu, exp pc, exp flush
      vq.push_back('{"add",      ALU_ADD,   32'd5,        32'd7,        16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE, BR_EQ, 13'h100,  32'd12,       13'h101,  1'b0});
      vq.push_back('{"sub_imm",  ALU_SUB,   32'd0,        32'd3,        16'hFFBF, 1'b1, 1'b0, 1'b0, 1'b0, BR_NONE, BR_EQ, 13'h100,  32'd60,       13'h101,  1'b0});
      vq.push_back('{"and",      ALU_AND,   32'hF0F0F0F0, 32'hFF00FF00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE, BR_EQ, 13'h100,  32'hF000F000, 13'h101,  1'b0});
      vq.push_back('{"or",       ALU_OR,    32'h0000000F, 32'h000000F0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE, BR_EQ, 13'h100,  32'h000000FF, 13'h101,  1'b0});
      vq.push_back('{"xor",      ALU_XOR,   32'hFFFF0000, 32'h0F0F0F0F, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE, BR_EQ, 13'h100,  32'hF0F00F0F, 13'h101,  1'b0});
      vq.push_back('{"sll_amt",  ALU_SLL,   32'd1,        32'h00000024, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE, BR_EQ, 13'h100,  32'h00000010, 13'h101,  1'b0});
      vq.push_back('{"srl31",    ALU_SRL,   32'h80000000, 32'd31,       16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE, BR_EQ, 13'h100,  32'd1,        13'h101,  1'b0});
      vq.push_back('{"sra",      ALU_SRA,   32'h80000000, 32'd4,        16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE, BR_EQ, 13'h100,  32'hF8000000, 13'h101,  1'b0});
      vq.push_back('{"slt_t",    ALU_SLT,   32'hFFFFFFFF, 32'd1,        16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE, BR_EQ, 13'h100,  32'd1,        13'h101,  1'b0});
      vq.push_back('{"slt_f",    ALU_SLT,   32'd1,        32'hFFFFFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE, BR_EQ, 13'h100,  32'd0,        13'h101,  1'b0});
      vq.push_back('{"passb_im", ALU_PASSB, 32'd0,        32'h0000DEAD, 16'h12AB, 1'b0, 1'b1, 1'b0, 1'b0, BR_NONE, BR_EQ, 13'h100,  32'h000000AB, 13'h101,  1'b0});
      vq.push_back('{"undef_op", 4'hF,      32'd9,        32'h00001234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE, BR_EQ, 13'h100,  32'h00001234, 13'h101,  1'b0});
      vq.push_back('{"add_wrap", ALU_ADD,   32'hFFFFFFFF, 32'd2,        16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE, BR_EQ, 13'h100,  32'd1,        13'h101,  1'b0});
      vq.push_back('{"beq_back", ALU_SUB,   32'd9,        32'd9,        16'h00FE, 1'b0, 1'b0, 1'b0, 1'b0, BR_COND, BR_EQ, 13'h0010, 32'd0,        13'h000E, 1'b1});
      vq.push_back('{"bne_nt",   ALU_ADD,   32'd9,        32'd9,        16'h00FE, 1'b0, 1'b0, 1'b0, 1'b0, BR_COND, BR_NE, 13'h0010, 32'd18,       13'h0011, 1'b0});
      vq.push_back('{"br_wrap",  ALU_ADD,   32'd0,        32'd0,        16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, BR_COND, BR_EQ, 13'h1FFF, 32'd0,        13'h0001, 1'b1});
      vq.push_back('{"blt",      ALU_ADD,   32'hFFFFFFFB, 32'd3,        16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, BR_COND, BR_LT, 13'h100,  32'hFFFFFFFE, 13'h110,  1'b1});
      vq.push_back('{"bgt_nt",   ALU_ADD,   32'hFFFFFFFB, 32'd3,        16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, BR_COND, BR_GT, 13'h100,  32'hFFFFFFFE, 13'h101,  1'b0});
      vq.push_back('{"ble_eq",   ALU_PASSB, 32'd4,        32'd4,        16'h0080, 1'b0, 1'b0, 1'b0, 1'b0, BR_COND, BR_LE, 13'h100,  32'd4,        13'h080,  1'b1});
      vq.push_back('{"bge",      ALU_SUB,   32'd3,        32'hFFFFFFFB, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, BR_COND, BR_GE, 13'h100,  32'd8,        13'h101,  1'b1});
      vq.push_back('{"jump",     ALU_PASSB, 32'hABCD1234, 32'd7,        16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, BR_JUMP, BR_EQ, 13'h100,  32'd7,        13'h1234, 1'b1});
      vq.push_back('{"fwd_a",    ALU_ADD,   32'h00000999, 32'd1,        16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, BR_EQ, 13'h100,  32'd8,        13'h101,  1'b0});
      vq.push_back('{"fwd_b",    ALU_SUB,   32'd20,       32'h00000555, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, BR_NONE, BR_EQ, 13'h100,  32'd12,       13'h101,  1'b0});
      vq.push_back('{"imm_fwd",  ALU_ADD,   32'd0,        32'd1,        16'h0005, 1'b1, 1'b0, 1'b1, 1'b0, BR_NONE, BR_EQ, 13'h100,  32'd6,        13'h101,  1'b0});
      vq.push_back('{"fwd_ab",   ALU_XOR,   32'h11111111, 32'h22222222, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, BR_NONE, BR_EQ, 13'h100,  32'd0,        13'h101,  1'b0});
      vq.push_back('{"fwd_cmp",  ALU_ADD,   32'd99,       32'd0,        16'h0004, 1'b0, 1'b0, 1'b1, 1'b0, BR_COND, BR_EQ, 13'h100,  32'd0,        13'h104,  1'b1});

      // Reset state.
      #1;
      checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst.alu_out", alu_out, 32'd0);
      checkOutput("rst.pc_out", 32'(pc_out), 32'd0);
      checkOutput("rst.flush", 32'(flush), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] applying %0d vectors back to back", vq.size());
      foreach (vq[i]) begin
         applyStimulus(vq[i]);
      end

      // Flush drops once the taken branch has transferred and nothing new arrives.
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("idle.out_valid", 32'(out_valid), 32'd0);
      checkOutput("idle.flush", 32'(flush), 32'd0);

      // MUL with branch fields set as a jump: they must be ignored.
      $display("[TB] MUL 0xFFFFFFFF * 3");
      driveOp(ALU_MUL, 32'hFFFFFFFF, 32'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, BR_JUMP, BR_EQ, 13'h0042);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         if (in_ready || out_valid) bad++;
         @(posedge clk);
         #1;
      end
      checkOutput("mul.busy_window", 32'(bad), 32'd0);
      checkOutput("mul.out_valid", 32'(out_valid), 32'd1);
      checkOutput("mul.alu_out", alu_out, 32'hFFFFFFFD);
      checkOutput("mul.pc_out", 32'(pc_out), 32'h0043);
      checkOutput("mul.flush", 32'(flush), 32'd0);

      // Downstream backpressure holds the MUL result while a new op waits.
      out_ready = 1'b0;
      driveOp(ALU_ADD, 32'd2, 32'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE, BR_EQ, 13'h0200);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("hold.alu_out", alu_out, 32'hFFFFFFFD);
         checkOutput("hold.pc_out", 32'(pc_out), 32'h0043);
         checkOutput("hold.out_valid", 32'(out_valid), 32'd1);
         checkOutput("hold.in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      checkOutput("release.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("release.alu_out", alu_out, 32'd5);
      checkOutput("release.pc_out", 32'(pc_out), 32'h0201);

      // Reset in the middle of a MUL aborts it.
      driveOp(ALU_MUL, 32'd7, 32'd6, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE, BR_EQ, 13'h0300);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("midmul.in_ready_low", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst.in_ready", 32'(in_ready), 32'd1);
      checkOutput("midrst.out_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst.alu_out", alu_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid || !in_ready) bad++;
      end
      checkOutput("midrst.aborted", 32'(bad), 32'd0);

      driveOp(ALU_SUB, 32'd100, 32'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE, BR_EQ, 13'h0010);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("post_rst.alu_out", alu_out, 32'd99);
      checkOutput("post_rst.out_valid", 32'(out_valid), 32'd1);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
